usb_bus_turnaround_ctrl: RTL

Sequential controller for the bidirectional USB D+/D- pair. It arbitrates between transmit and receive direction with a configurable bus-turnaround gap, and registers the drive values. It synchronises the received line, decodes line state (J/K/SE0/SE1) and detects receive EOP. It sits between the USB TX encoder / RX decoder and the top-level D+/D- pads.

---
 rtl/usb_bus_turnaround_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/usb_bus_turnaround_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : usb_bus_turnaround_ctrl
// Brief    : USB D+/D- direction arbiter with turnaround gap, RX line sync,
//            line-state decode and EOP detection.
// Revision : 1.0 - initial release
// ============================================================================
module usb_bus_turnaround_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int TA_CYCLES   = 2,
    parameter int EOP_SE0_MIN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_req,
    input  logic       d_plus_out,
    input  logic       d_minus_out,
    output logic       tx_grant,
    inout  wire        d_plus,
    inout  wire        d_minus,
    output logic       d_plus_in,
    output logic       d_minus_in,
    output logic [1:0] line_state,
    output logic       rx_eop,
    output logic       receiving
);

    localparam int c_TA_W  = $clog2(TA_CYCLES + 1);
    localparam int c_SE0_W = $clog2(EOP_SE0_MIN + 1);

    localparam logic [c_TA_W-1:0]  c_TA_LAST = c_TA_W'(TA_CYCLES - 1);
    localparam logic [c_TA_W-1:0]  c_TA_ONE  = c_TA_W'(1);
    localparam logic [c_SE0_W-1:0] c_SE0_MAX = c_SE0_W'(EOP_SE0_MIN);
    localparam logic [c_SE0_W-1:0] c_SE0_ONE = c_SE0_W'(1);

    localparam logic [1:0] c_LS_J   = 2'b10;
    localparam logic [1:0] c_LS_SE0 = 2'b00;

    localparam logic [1:0] c_ST_RX    = 2'd0;
    localparam logic [1:0] c_ST_TA_TX = 2'd1;
    localparam logic [1:0] c_ST_TX    = 2'd2;
    localparam logic [1:0] c_ST_TA_RX = 2'd3;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_TA_W-1:0]      r_ta_cnt;
    logic [c_TA_W-1:0]      w_ta_nxt;
    logic [c_SE0_W-1:0]     r_se0_cnt;
    logic                   r_oe;
    logic                   r_dp_q;
    logic                   r_dm_q;
    logic [SYNC_STAGES-1:0] r_dp_sync;
    logic [SYNC_STAGES-1:0] r_dm_sync;

    always_comb begin
        w_state_nxt = r_state;
        w_ta_nxt    = r_ta_cnt;
        case (r_state)
            c_ST_RX: begin
                // Only take the bus from an idle (J) line.
                if (tx_req && (line_state == c_LS_J)) begin
                    w_state_nxt = c_ST_TA_TX;
                    w_ta_nxt    = '0;
                end
            end
            c_ST_TA_TX: begin
                if (!tx_req) begin
                    w_state_nxt = c_ST_RX;
                end else if (r_ta_cnt == c_TA_LAST) begin
                    w_state_nxt = c_ST_TX;
                end else begin
                    w_ta_nxt = r_ta_cnt + c_TA_ONE;
                end
            end
            c_ST_TX: begin
                if (!tx_req) begin
                    w_state_nxt = c_ST_TA_RX;
                    w_ta_nxt    = '0;
                end
            end
            c_ST_TA_RX: begin
                if (r_ta_cnt == c_TA_LAST) begin
                    w_state_nxt = c_ST_RX;
                end else begin
                    w_ta_nxt = r_ta_cnt + c_TA_ONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_RX;
                w_ta_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_RX;
            r_ta_cnt  <= '0;
            r_oe      <= 1'b0;
            r_dp_q    <= 1'b1;
            r_dm_q    <= 1'b0;
            r_dp_sync <= '1;
            r_dm_sync <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ta_cnt  <= w_ta_nxt;
            r_oe      <= (w_state_nxt == c_ST_TX);
            r_dp_q    <= (w_state_nxt == c_ST_TX) ? d_plus_out  : 1'b1;
            r_dm_q    <= (w_state_nxt == c_ST_TX) ? d_minus_out : 1'b0;
            r_dp_sync <= {r_dp_sync[SYNC_STAGES-2:0], d_plus};
            r_dm_sync <= {r_dm_sync[SYNC_STAGES-2:0], d_minus};
        end
    end

    // SE0 run length; cleared on any other line value and whenever RX is left.
    always_ff @(posedge clk) begin
        if (rst || (r_state != c_ST_RX) || (w_state_nxt != c_ST_RX)) begin
            r_se0_cnt <= '0;
        end else if (line_state == c_LS_SE0) begin
            if (r_se0_cnt != c_SE0_MAX) begin
                r_se0_cnt <= r_se0_cnt + c_SE0_ONE;
            end
        end else begin
            r_se0_cnt <= '0;
        end
    end

    assign receiving  = (r_state == c_ST_RX);
    assign tx_grant   = (r_state == c_ST_TX);
    assign d_plus_in  = receiving ? r_dp_sync[SYNC_STAGES-1] : 1'b1;
    assign d_minus_in = receiving ? r_dm_sync[SYNC_STAGES-1] : 1'b0;
    assign line_state = {d_plus_in, d_minus_in};
    assign rx_eop     = receiving && (line_state == c_LS_J) && (r_se0_cnt >= c_SE0_MAX);

    assign d_plus  = r_oe ? r_dp_q : 1'bz;
    assign d_minus = r_oe ? r_dm_q : 1'bz;

endmodule
`default_nettype wire
